// File: rtl/interleaver_pkg.sv
// Shared definitions for the interleaver datapath and its counting-pattern
// source/checker pair.
package interleaver_pkg;

    localparam int CODEWORD_SIZE_IN_32_DEF = 65;
    localparam int NUM_CODEWORDS_DEF       = 4;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr_ready_gen.sv
// Registered tready source: constant high, or gated by a free-running 16-bit
// Fibonacci LFSR for pseudo-random backpressure.
module lfsr_ready_gen
    import interleaver_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int          MODE = 0
) (
    input  logic clk,
    input  logic rst,
    output logic tready
);

    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr   <= SEED;
            tready <= 1'b0;
        end else begin
            lfsr   <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            tready <= (MODE == 0) ? 1'b1 : (lfsr[2:0] != 3'd0);
        end
    end

endmodule

// File: rtl/axis_seq_checker.sv
// AXI-Stream sink that locks onto the codeword counting pattern and reports
// mismatches, counts and the most recent bad word.
module axis_seq_checker
    import interleaver_pkg::*;
#(
    parameter int          CODEWORD_SIZE_IN_32 = CODEWORD_SIZE_IN_32_DEF,
    parameter int          LOCK_COUNT          = 8,
    parameter int          UNLOCK_ERRS         = 4,
    parameter int          BP_MODE             = 0,
    parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        locked,
    output logic        err_pulse,
    output logic [31:0] err_cnt,
    output logic [47:0] word_cnt,
    output logic [31:0] last_exp,
    output logic [31:0] last_got
);

    localparam logic [31:0] MAX_VAL = 32'(CODEWORD_SIZE_IN_32 - 1);
    localparam int          GW      = $clog2(LOCK_COUNT + 1);
    localparam int          BW      = $clog2(UNLOCK_ERRS + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_ERRS - 1);

    function automatic logic [31:0] nxt(input logic [31:0] v);
        return (v == MAX_VAL) ? 32'd1 : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    chk_state_t    state;
    logic [31:0]   exp_q;
    logic          exp_vld;
    logic [GW-1:0] good_run;
    logic [BW-1:0] bad_run;
    logic          acc;
    logic          hit;

    lfsr_ready_gen #(
        .SEED (LFSR_SEED),
        .MODE (BP_MODE)
    ) u_ready (
        .clk    (clk),
        .rst    (rst),
        .tready (s_axis_tready)
    );

    // Out-of-range data can never match, even if a reseed happened to equal it.
    assign acc    = s_axis_tvalid && s_axis_tready;
    assign hit    = exp_vld && (s_axis_tdata == exp_q) && (s_axis_tdata <= MAX_VAL);
    assign locked = (state == ST_LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_SEARCH;
            exp_q     <= '0;
            exp_vld   <= 1'b0;
            good_run  <= '0;
            bad_run   <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            word_cnt  <= '0;
            last_exp  <= '0;
            last_got  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (acc) begin
                word_cnt <= word_cnt + 48'd1;
                if (state == ST_SEARCH) begin
                    exp_q   <= nxt(s_axis_tdata);
                    exp_vld <= 1'b1;
                    if (!hit) begin
                        good_run <= '0;
                    end else if (good_run == GOOD_LAST) begin
                        state    <= ST_LOCKED;
                        good_run <= '0;
                        bad_run  <= '0;
                    end else begin
                        good_run <= good_run + GW'(1);
                    end
                end else begin
                    // Free-running expectation: one corrupt word costs one error.
                    exp_q <= nxt(exp_q);
                    if (hit) begin
                        bad_run <= '0;
                    end else begin
                        err_pulse <= 1'b1;
                        err_cnt   <= sat_inc(err_cnt);
                        last_exp  <= exp_q;
                        last_got  <= s_axis_tdata;
                        if (bad_run == BAD_LAST) begin
                            state    <= ST_SEARCH;
                            bad_run  <= '0;
                            good_run <= '0;
                            exp_vld  <= 1'b0;
                        end else begin
                            bad_run <= bad_run + BW'(1);
                        end
                    end
                end
            end
            if (clr) begin
                err_cnt  <= '0;
                word_cnt <= '0;
                last_exp <= '0;
                last_got <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axis_seq_checker.sv
// Scoreboard bench for axis_seq_checker: one instance without and one with
// LFSR backpressure, both checked against a behavioural model.
module tb_axis_seq_checker;

    localparam int CW = 65;

    typedef struct {
        logic        lk;
        logic        ep;
        logic [31:0] ec;
        logic [47:0] wc;
        logic [31:0] le;
        logic [31:0] lg;
    } exp_rec_t;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [31:0] tdata0, tdata1;
    logic        tvalid0, tvalid1;
    logic        tready0, tready1;
    logic        locked0, locked1;
    logic        errp0, errp1;
    logic [31:0] errc0, errc1;
    logic [47:0] wc0, wc1;
    logic [31:0] le0, le1, lg0, lg1;

    int n_chk  = 0;
    int n_fail = 0;

    exp_rec_t sb[$];

    // Behavioural model state
    bit          m_lock;
    bit          m_ev;
    logic [31:0] m_exp;
    int          m_good;
    int          m_bad;
    logic [31:0] m_errc;
    logic [47:0] m_wc;
    logic [31:0] m_le;
    logic [31:0] m_lg;

    axis_seq_checker #(.BP_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr),
        .s_axis_tdata(tdata0), .s_axis_tvalid(tvalid0), .s_axis_tready(tready0),
        .locked(locked0), .err_pulse(errp0), .err_cnt(errc0), .word_cnt(wc0),
        .last_exp(le0), .last_got(lg0)
    );

    axis_seq_checker #(.BP_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .clr(1'b0),
        .s_axis_tdata(tdata1), .s_axis_tvalid(tvalid1), .s_axis_tready(tready1),
        .locked(locked1), .err_pulse(errp1), .err_cnt(errc1), .word_cnt(wc1),
        .last_exp(le1), .last_got(lg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] nxt_val(input logic [31:0] v);
        return (v == CW - 1) ? 32'd1 : v + 32'd1;
    endfunction

    task automatic model_reset();
        m_lock = 0; m_ev = 0; m_exp = 0; m_good = 0; m_bad = 0;
        m_errc = 0; m_wc = 0; m_le = 0; m_lg = 0;
        sb.delete();
    endtask

    task automatic model_step(input bit acc, input logic [31:0] got, input bit c);
        exp_rec_t e;
        e.ep = 1'b0;
        if (acc) begin
            m_wc = m_wc + 48'd1;
            if (!m_lock) begin
                if (m_ev && got == m_exp && got < CW) m_good++;
                else m_good = 0;
                m_exp = nxt_val(got);
                m_ev  = 1;
                if (m_good == 8) begin m_lock = 1; m_good = 0; m_bad = 0; end
            end else begin
                if (got == m_exp) m_bad = 0;
                else begin
                    e.ep = 1'b1;
                    if (m_errc != 32'hFFFF_FFFF) m_errc = m_errc + 1;
                    m_le = m_exp;
                    m_lg = got;
                    m_bad++;
                end
                m_exp = nxt_val(m_exp);
                if (m_bad == 4) begin m_lock = 0; m_good = 0; m_bad = 0; m_ev = 0; end
            end
        end
        if (c) begin m_errc = 0; m_wc = 0; m_le = 0; m_lg = 0; end
        e.lk = m_lock; e.ec = m_errc; e.wc = m_wc; e.le = m_le; e.lg = m_lg;
        sb.push_back(e);
    endtask

    task automatic compare(input string tag, input logic lk, input logic ep,
                           input logic [31:0] ec, input logic [47:0] wc,
                           input logic [31:0] le, input logic [31:0] lg);
        exp_rec_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".locked"}, 64'(lk), 64'(e.lk));
            chk({tag, ".err_pulse"}, 64'(ep), 64'(e.ep));
            chk({tag, ".err_cnt"}, 64'(ec), 64'(e.ec));
            chk({tag, ".word_cnt"}, 64'(wc), 64'(e.wc));
            chk({tag, ".last_exp"}, 64'(le), 64'(e.le));
            chk({tag, ".last_got"}, 64'(lg), 64'(e.lg));
        end
    endtask

    // Mode-0 instance: one word per cycle, tready sampled before the edge.
    task automatic send0(input logic [31:0] d, input bit c);
        bit acc;
        tdata0 = d; tvalid0 = 1'b1; clr = c;
        acc = tready0;
        model_step(acc, d, c);
        @(posedge clk); #1;
        tvalid0 = 1'b0; clr = 1'b0;
        compare("w0", locked0, errp0, errc0, wc0, le0, lg0);
    endtask

    task automatic clr0();
        clr = 1'b1;
        model_step(1'b0, 32'd0, 1'b1);
        @(posedge clk); #1;
        clr = 1'b0;
        compare("clr0", locked0, errp0, errc0, wc0, le0, lg0);
    endtask

    // Mode-1 instance: random tvalid gaps against LFSR tready.
    task automatic send1(input logic [31:0] d);
        bit done;
        int guard;
        done = 0; guard = 0;
        tdata1 = d;
        while (!done) begin
            tvalid1 = ($urandom_range(0, 3) != 0);
            done = tvalid1 && tready1;
            if (done) model_step(1'b1, d, 1'b0);
            @(posedge clk); #1;
            if (done) compare("w1", locked1, errp1, errc1, wc1, le1, lg1);
            else chk("stall_no_pulse", 64'(errp1), 64'd0);
            guard++;
            if (!done && guard > 64) begin
                chk("tready_timeout", 64'd1, 64'd0);
                done = 1;
            end
        end
        tvalid1 = 1'b0;
    endtask

    initial begin
        logic [31:0] pv;
        bit corrupted;
        rst = 1'b1; clr = 1'b0;
        tdata0 = '0; tdata1 = '0; tvalid0 = 1'b0; tvalid1 = 1'b0;
        model_reset();

        // Reset and idle
        repeat (4) begin
            @(posedge clk); #1;
            chk("rst_tready0", 64'(tready0), 64'd0);
            chk("rst_tready1", 64'(tready1), 64'd0);
            chk("rst_locked", 64'(locked0), 64'd0);
            chk("rst_outs", {errp0, errc0, wc0[30:0]}, 64'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("tready_after_rst", 64'(tready0), 64'd1);
        chk("idle_locked", 64'(locked0), 64'd0);
        chk("idle_wc", 64'(wc0), 64'd0);

        // Clean stream 0,1..64 x3
        pv = 32'd0;
        for (int i = 0; i < 193; i++) begin
            send0(pv, 1'b0);
            pv = nxt_val(pv);
            if (i == 7) chk("not_locked_8th", 64'(locked0), 64'd0);
            if (i == 8) chk("locked_9th", 64'(locked0), 64'd1);
        end
        chk("clean_wc", 64'(wc0), 64'd193);
        chk("clean_errc", 64'(errc0), 64'd0);

        // Single corruption while locked
        corrupted = 0;
        for (int i = 0; i < 64; i++) begin
            if (pv == 32'd37 && !corrupted) begin
                send0(32'd99, 1'b0);
                corrupted = 1;
                chk("corr_pulse", 64'(errp0), 64'd1);
                chk("corr_errc", 64'(errc0), 64'd1);
                chk("corr_last_exp", 64'(le0), 64'd37);
                chk("corr_last_got", 64'(lg0), 64'd99);
            end else begin
                send0(pv, 1'b0);
            end
            pv = nxt_val(pv);
        end
        chk("corr_still_locked", 64'(locked0), 64'd1);
        chk("corr_errc_final", 64'(errc0), 64'd1);

        // Loss of lock and re-lock
        clr0();
        chk("clr_errc", 64'(errc0), 64'd0);
        for (int i = 0; i < 4; i++) begin
            send0(32'd500 + 32'(i), 1'b0);
            pv = nxt_val(pv);
            if (i == 2) chk("lock_held_3bad", 64'(locked0), 64'd1);
        end
        chk("unlock_4bad", 64'(locked0), 64'd0);
        chk("unlock_errc", 64'(errc0), 64'd4);
        for (int i = 0; i < 9; i++) begin
            send0(pv, 1'b0);
            pv = nxt_val(pv);
        end
        chk("relock", 64'(locked0), 64'd1);
        chk("relock_errc", 64'(errc0), 64'd4);

        // clr colliding with a mismatch
        send0(32'd777, 1'b1);
        pv = nxt_val(pv);
        chk("clr_coll_pulse", 64'(errp0), 64'd1);
        chk("clr_coll_errc", 64'(errc0), 64'd0);
        chk("clr_coll_wc", 64'(wc0), 64'd0);
        send0(32'd888, 1'b0);
        pv = nxt_val(pv);
        for (int i = 0; i < 5; i++) begin
            send0(pv, 1'b0);
            pv = nxt_val(pv);
        end

        // Asynchronous reset mid-block
        rst = 1'b1;
        #2;
        chk("arst_tready", 64'(tready0), 64'd0);
        chk("arst_locked", 64'(locked0), 64'd0);
        chk("arst_pulse", 64'(errp0), 64'd0);
        chk("arst_errc", 64'(errc0), 64'd0);
        chk("arst_wc", 64'(wc0), 64'd0);
        chk("arst_capture", {le0, lg0}, 64'd0);
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Wrap and backpressure on the mode-1 instance, 2 blocks
        pv = 32'd0;
        for (int i = 0; i < 520; i++) begin
            send1(pv);
            pv = nxt_val(pv);
        end
        chk("bp_locked", 64'(locked1), 64'd1);
        chk("bp_errc", 64'(errc1), 64'd0);
        chk("bp_wc", 64'(wc1), 64'd520);
        chk("bp_sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/axis_seq_checker.md
# axis_seq_checker

Synthesizable AXI-Stream sink that consumes the de-interleaver output and checks it against the project's codeword counting pattern. It is the receive-side counterpart of the counting-pattern source that feeds `pre_interleaver_v1`, and sits after `de_interleaver_v1` on-chip or in loopback benches. It optionally generates pseudo-random `tready` backpressure. It reports lock state, error pulses, saturating error count, word count, and the most recent mismatch.

## Interface
- `CODEWORD_SIZE_IN_32`, default 65 — pattern period source; legal values are 1..`CODEWORD_SIZE_IN_32`-1.
- `LOCK_COUNT`, default 8 — consecutive good words needed to lock.
- `UNLOCK_ERRS`, default 4 — consecutive bad words that drop lock.
- `BP_MODE`, default 0 — 0 = `tready` always high after reset; 1 = LFSR-driven `tready`.
- `LFSR_SEED`, default 16'hACE1 — backpressure LFSR seed; must be nonzero.

Ports:
- `clk` in 1 — single clock.
- `rst` in 1 — asynchronous, active-high reset.
- `clr` in 1 — synchronous clear of the counters and capture registers; lock state is unaffected.
- `s_axis_tdata` in 32 — data under check.
- `s_axis_tvalid` in 1 — data valid.
- `s_axis_tready` out 1 — checker ready.
- `locked` out 1 — pattern lock.
- `err_pulse` out 1 — one-cycle pulse per mismatched accepted word.
- `err_cnt` out 32 — mismatches counted while locked; saturates at 32'hFFFFFFFF.
- `word_cnt` out 48 — accepted words; wraps.
- `last_exp` out 32 — expected value at the most recent mismatch.
- `last_got` out 32 — received value at the most recent mismatch.

## Operation
- Accept: `s_axis_tvalid && s_axis_tready` at a rising edge. Only accepted words affect state.
- Successor function: `nxt(v) = (v == CODEWORD_SIZE_IN_32-1) ? 1 : v+1`. The first word after a source reset is 0, and `nxt(0)=1`.
- Out of range: any value greater than `CODEWORD_SIZE_IN_32`-1 never matches.

State machine with two states, SEARCH and LOCKED:
- SEARCH (reset state): `exp` is reseeded from every accepted word, `exp <= nxt(got)`.
  - If `got == exp` and `exp` is valid: `good_run++`; otherwise `good_run <= 0`.
  - When `good_run` reaches `LOCK_COUNT`, go to LOCKED.
  - The first accepted word after reset or unlock only seeds `exp` and counts neither good nor bad.
  - No `err_pulse` is raised and `err_cnt` does not change in SEARCH.
- LOCKED: `exp` advances from itself, `exp <= nxt(exp)`, so a single corrupt word yields exactly one error.
  - Mismatch: assert `err_pulse`, increment `err_cnt` (saturating), capture `last_exp` and `last_got`, and `bad_run++`.
  - Match: `bad_run <= 0`.
  - When `bad_run` reaches `UNLOCK_ERRS`, go to SEARCH, clear `good_run`, and invalidate `exp`.
- `word_cnt` increments on every accepted word in both states.

Backpressure:
- 16-bit Fibonacci LFSR with taps 16,14,13,11, seeded with `LFSR_SEED`, advancing every cycle.
- In mode 1, `tready` is low when `lfsr[2:0]==0` (about 1/8 of cycles).

`clr`:
- Clears `err_cnt`, `word_cnt`, `last_exp` and `last_got`.
- If `clr` coincides with an accept or error in the same cycle, the clear wins for the counters; the `err_pulse` is still raised.

## Timing
- Reset values:
  - `s_axis_tready`=0, `locked`=0, `err_pulse`=0.
  - `err_cnt`, `word_cnt`, `last_exp`, `last_got` = 0.
  - State SEARCH; LFSR = `LFSR_SEED`.
- `s_axis_tready` is registered. It rises on the first edge after `rst` deasserts: mode 0 holds it at 1, mode 1 follows the LFSR.
- `s_axis_tready` does not depend combinationally on `tvalid`.
- One-cycle latency for all status outputs. `err_pulse`, `err_cnt`, `word_cnt` and the capture registers update on the edge after the accepting edge.
- `locked` asserts on the edge after the `LOCK_COUNT`-th good word, and deasserts on the edge after the `UNLOCK_ERRS`-th consecutive bad word.
- A `tvalid` gap or a `tready` stall does not advance `exp` or the runs.
- If `rst` is asserted mid-stream, all state returns to the reset values immediately (asynchronously); no partial-word state survives.

## Structure
- Shared `interleaver_pkg` holds:
  - the `CODEWORD_SIZE_IN_32` default (65) and `NUM_CODEWORDS` default (4);
  - checker state encodings (SEARCH=1'b0, LOCKED=1'b1);
  - the LFSR tap constant.
- One sub-module, `lfsr_ready_gen` (LFSR plus `tready` register, parameterized by seed and mode), which the source side also reuses.
- Expected RTL size is roughly 200 lines total.

## Test plan
- **Reset and idle:** hold `rst` 4 cycles, no `tvalid` → all outputs 0 during reset; in mode 0 `tready`=1 one cycle after release; `locked` stays 0.
- **Clean stream:** stream 0,1..64,1..64 ×3 in mode 0 → `locked`=1 after the 9th word (seed word plus 8 good), `err_cnt`=0, `word_cnt`=193.
- **Single corruption while locked:** replace one 37 with 99 → exactly one `err_pulse`, `err_cnt`=1, `last_exp`=37, `last_got`=99, and `locked` stays 1.
- **Loss of lock:** inject 4 consecutive bad words → `locked` drops after the 4th, `err_cnt`=4; then 9 good words re-lock with no further `err_cnt` increments.
- **Wrap and backpressure:** mode 1 with a random `tvalid` gap source, 2 blocks (520 words) → `locked`=1, `err_cnt`=0, `word_cnt`=520, and 64→1 is never flagged.
- **Clear and reset collisions:** `clr` in the same cycle as a mismatch → `err_pulse`=1 and `err_cnt`=0 next cycle; `rst` asserted mid-block → outputs return to reset values immediately.
